// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of an asynchronous FIFO.
// It keeps the binary and Gray read pointers and the registered empty flag.
// It drives the memory read port and feeds a 2-entry skid buffer, so the
// output stream runs at full rate and tolerates backpressure.
//
// Parameters
//   DATASIZE    - memory data word width
//   ADDRSIZE    - memory address bits (depth 2**ADDRSIZE)
//   FALLTHROUGH - "TRUE": combinational memory read (latency 0);
//                 any other value: registered read gated by rclken (latency 1)
//
// Ports
//   rclk       - read clock, the block's only clock (rising edge)
//   rrst       - synchronous active-high reset
//   rq2_wptr   - Gray write pointer, already synchronised into rclk
//   raddr      - memory read address
//   rclken     - memory read enable / pop strobe
//   rdata_mem  - memory read data
//   rptr       - registered Gray read pointer, sent to the write side
//   rempty     - registered FIFO-empty flag
//   rlevel     - registered fill level (only with FIFO_RD_LEVEL_EN)
//   m_valid/m_ready/m_data - output stream
//
// Optional feature: define FIFO_RD_LEVEL_EN to add the rlevel output.
module fifo_rd_ctrl #(
  parameter int unsigned DATASIZE    = 8,
  parameter int unsigned ADDRSIZE    = 4,
  parameter string       FALLTHROUGH = "TRUE"
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic                rclken,
  input  logic [DATASIZE-1:0] rdata_mem,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
`ifdef FIFO_RD_LEVEL_EN
  output logic [ADDRSIZE:0]   rlevel,
`endif
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data
);

  localparam int unsigned PW       = ADDRSIZE + 1;
  localparam bit          REG_READ = (FALLTHROUGH != "TRUE");

  logic [PW-1:0]       rbin;
  logic [PW-1:0]       rbin_next;
  logic [PW-1:0]       rgray_next;
  logic                pop;
  logic                fire;
  logic                capture;
  logic                credit_ok;
  logic [2:0]          occ;
  logic [1:0]          count;
  logic [1:0]          count_next;
  logic                inflight;
  logic [DATASIZE-1:0] buf1;

  // Pop control: a pop is allowed only when the word it fetches is sure to
  // find room in the skid buffer, counting the word still in the memory
  // pipeline and the word leaving on this edge.
  always_comb begin
    fire       = m_valid && m_ready;
    occ        = 3'(count) + 3'(inflight) - 3'(fire);
    credit_ok  = (occ < 3'd2);
    pop        = !rempty && credit_ok && !rrst;
    rbin_next  = rbin + PW'(pop);
    rgray_next = (rbin_next >> 1) ^ rbin_next;
    // Registered memory returns data one cycle after the pop edge.
    capture    = REG_READ ? inflight : pop;
    count_next = count + 2'(capture) - 2'(fire);
  end

  assign raddr  = rbin[ADDRSIZE-1:0];
  assign rclken = pop;

  // Pointers, empty flag and skid buffer; m_data is the buffer head.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin     <= '0;
      rptr     <= '0;
      rempty   <= 1'b1;
      inflight <= 1'b0;
      count    <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      buf1     <= '0;
    end else begin
      rbin     <= rbin_next;
      rptr     <= rgray_next;
      rempty   <= (rgray_next == rq2_wptr);
      inflight <= REG_READ && pop;
      count    <= count_next;
      m_valid  <= (count_next != 2'd0);
      case ({capture, fire})
        2'b11: begin
          // Head leaves while a new word arrives.
          if (count == 2'd2) begin
            m_data <= buf1;
            buf1   <= rdata_mem;
          end else begin
            m_data <= rdata_mem;
          end
        end
        2'b10: begin
          if (count == 2'd0) m_data <= rdata_mem;
          else               buf1   <= rdata_mem;
        end
        2'b01: m_data <= buf1;
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Fill level as seen from the read side (write pointer is synchronised).
  always_ff @(posedge rclk) begin
    if (rrst) rlevel <= '0;
    else      rlevel <= gray2bin(rq2_wptr) - rbin;
  end
`endif

endmodule
